// File: rtl/lsu_mem_ctrl_if.sv
// CPU request/response and byte-memory bus between the load/store controller and its neighbours.
interface lsu_mem_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  // CPU side
  logic                  cpu_req_valid;
  logic                  cpu_req_ready;
  logic                  cpu_we;
  logic [1:0]            cpu_size;
  logic                  cpu_unsigned;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_resp_valid;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_err;
  // Memory side
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_req_valid;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_data_oe;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_data_valid;

  // Environment: issues CPU requests and models the memory
  modport master (
    output cpu_req_valid, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata,
    output mem_rdata, mem_data_valid,
    input  cpu_req_ready, cpu_resp_valid, cpu_rdata, cpu_err,
    input  mem_addr, mem_req_valid, mem_we, mem_wdata, mem_data_oe
  );

  // Controller: serves CPU requests and drives the memory bus
  modport slave (
    input  cpu_req_valid, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata,
    input  mem_rdata, mem_data_valid,
    output cpu_req_ready, cpu_resp_valid, cpu_rdata, cpu_err,
    output mem_addr, mem_req_valid, mem_we, mem_wdata, mem_data_oe
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller for a byte-wide-write main memory. Loads use one 4-byte read;
// stores are split into one write beat per byte. Misalignment and timeouts return err.
module lsu_mem_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 15
) (
  input logic           clk,
  input logic           reset,
  lsu_mem_ctrl_if.slave bus
);
  localparam int unsigned CntWidth = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

  typedef enum logic [2:0] {StIdle, StRdReq, StRdWait, StWrBeat, StWrWait, StResp} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [1:0]            beat_q, beat_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;

  logic                  data_valid;
  logic                  misaligned;
  logic [1:0]            last;
  logic [CntWidth-1:0]   cnt_inc;
  logic                  timeout_hit;
  logic [DATA_WIDTH-1:0] ld_ext;
  logic [7:0]            wr_byte;

  // Only a clean 1 counts as completion; X/Z from an undriven bus must not.
  assign data_valid = (bus.mem_data_valid === 1'b1);

  assign misaligned = (bus.cpu_size == 2'b11) ||
                      (bus.cpu_size == 2'b01 && bus.cpu_addr[0]) ||
                      (bus.cpu_size == 2'b10 && bus.cpu_addr[1:0] != 2'b00);

  assign cnt_inc     = cnt_q + 1'b1;
  assign timeout_hit = (cnt_inc == CntWidth'(TIMEOUT));

  // Index of the final store beat for the latched size
  always_comb begin
    last = 2'd3;
    case (size_q)
      2'b00:   last = 2'd0;
      2'b01:   last = 2'd1;
      default: last = 2'd3;
    endcase
  end

  // Load extraction from the little-endian read word, with sign/zero extension
  always_comb begin
    ld_ext = bus.mem_rdata;
    case (size_q)
      2'b00: ld_ext = uns_q ? {{(DATA_WIDTH-8){1'b0}}, bus.mem_rdata[7:0]}
                            : {{(DATA_WIDTH-8){bus.mem_rdata[7]}}, bus.mem_rdata[7:0]};
      2'b01: ld_ext = uns_q ? {{(DATA_WIDTH-16){1'b0}}, bus.mem_rdata[15:0]}
                            : {{(DATA_WIDTH-16){bus.mem_rdata[15]}}, bus.mem_rdata[15:0]};
      default: ld_ext = bus.mem_rdata;
    endcase
  end

  // Store byte selected by the current beat
  always_comb begin
    wr_byte = wdata_q[7:0];
    case (beat_q)
      2'd0: wr_byte = wdata_q[7:0];
      2'd1: wr_byte = wdata_q[15:8];
      2'd2: wr_byte = wdata_q[23:16];
      2'd3: wr_byte = wdata_q[31:24];
      default: wr_byte = wdata_q[7:0];
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.cpu_req_valid) begin
          addr_d  = bus.cpu_addr;
          we_d    = bus.cpu_we;
          size_d  = bus.cpu_size;
          uns_d   = bus.cpu_unsigned;
          wdata_d = bus.cpu_wdata;
          beat_d  = 2'd0;
          cnt_d   = '0;
          err_d   = 1'b0;
          if (misaligned) begin
            err_d   = 1'b1;
            state_d = StResp;
          end else if (bus.cpu_we) begin
            state_d = StWrBeat;
          end else begin
            state_d = StRdReq;
          end
        end
      end
      StRdReq: begin
        cnt_d   = '0;
        state_d = StRdWait;
      end
      StRdWait: begin
        if (data_valid) begin
          rdata_d = ld_ext;
          err_d   = 1'b0;
          state_d = StResp;
        end else begin
          cnt_d = cnt_inc;
          if (timeout_hit) begin
            err_d   = 1'b1;
            state_d = StResp;
          end
        end
      end
      StWrBeat: begin
        cnt_d   = '0;
        state_d = StWrWait;
      end
      StWrWait: begin
        if (data_valid) begin
          if (beat_q == last) begin
            err_d   = 1'b0;
            state_d = StResp;
          end else begin
            beat_d  = beat_q + 2'd1;
            state_d = StWrBeat;
          end
        end else begin
          cnt_d = cnt_inc;
          if (timeout_hit) begin
            err_d   = 1'b1;
            state_d = StResp;
          end
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      beat_q  <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs come from registers or state decode only
  assign bus.cpu_req_ready  = (state_q == StIdle);
  assign bus.cpu_resp_valid = (state_q == StResp);
  assign bus.cpu_err        = err_q;
  assign bus.cpu_rdata      = rdata_q;
  assign bus.mem_req_valid  = (state_q == StRdReq) || (state_q == StWrBeat);
  assign bus.mem_we         = (state_q == StWrBeat);
  assign bus.mem_data_oe    = (state_q == StWrBeat);
  assign bus.mem_addr       = addr_q + ADDR_WIDTH'(beat_q);
  assign bus.mem_wdata      = {{(DATA_WIDTH-8){1'b0}}, wr_byte};

  logic unused_we;
  assign unused_we = we_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed cases plus randomized requests against a byte-array model.
module tb_lsu_mem_ctrl;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic preload = 1'b1;
  int   mem_mode = 0;  // 0: normal memory, 1: data_valid stuck at 0

  always #5 clk = ~clk;

  lsu_mem_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  lsu_mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference memory image, updated from the architectural rules
  logic [7:0]  ref_mem [256];
  logic [31:0] prev_rd;
  int          n_pass = 0;
  int          n_total = 0;

  // Memory model: answers each request one cycle later; a write stores one byte
  logic [7:0]  tb_mem [256];
  logic        dv_q = 1'b0;
  logic [31:0] rd_q = '0;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= ref_mem[i];
      dv_q <= 1'b0;
    end else begin
      dv_q <= bus.mem_req_valid && (mem_mode == 0);
      if (bus.mem_req_valid && bus.mem_we) tb_mem[bus.mem_addr[7:0]] <= bus.mem_wdata[7:0];
      if (bus.mem_req_valid && !bus.mem_we)
        rd_q <= {tb_mem[8'(bus.mem_addr[7:0] + 8'd3)], tb_mem[8'(bus.mem_addr[7:0] + 8'd2)],
                 tb_mem[8'(bus.mem_addr[7:0] + 8'd1)], tb_mem[bus.mem_addr[7:0]]};
    end
  end
  assign bus.mem_data_valid = dv_q;
  assign bus.mem_rdata      = rd_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_load(input logic [1:0] size, input logic uns,
                                           input logic [31:0] addr);
    logic [31:0] v;
    int nb;
    v  = '0;
    nb = 1 << size;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[8'(addr + 32'(i))];
    if (!uns && nb < 4 && v[8*nb-1])
      for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  // One request from presentation to response, checked against the model
  task automatic run_req(input string tag, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input int mode);
    bit          mis;
    int          nb, exp_lat, exp_nreq, lat, nreq;
    logic        exp_err, got;
    logic [31:0] exp_rd;
    logic [31:0] exp_addr [4];
    logic [7:0]  exp_wd [4];
    logic [31:0] obs_addr [8];
    logic [31:0] obs_wd [8];
    logic        obs_we [8];
    logic        obs_oe [8];

    mis = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    nb  = 1 << size;
    for (int i = 0; i < 4; i++) begin
      exp_addr[i] = addr + 32'(i);
      exp_wd[i]   = wdata[8*i +: 8];
    end
    exp_rd = prev_rd;
    if (mis) begin
      exp_lat = 1; exp_err = 1'b1; exp_nreq = 0;
    end else if (mode != 0) begin
      exp_lat = 2 + TIMEOUT; exp_err = 1'b1; exp_nreq = 1;
      if (we) ref_mem[addr[7:0]] = wdata[7:0];
    end else if (we) begin
      exp_lat = 2 * nb + 1; exp_err = 1'b0; exp_nreq = nb;
      for (int i = 0; i < nb; i++) ref_mem[8'(addr + 32'(i))] = wdata[8*i +: 8];
    end else begin
      exp_lat = 3; exp_err = 1'b0; exp_nreq = 1;
      exp_rd  = exp_load(size, uns, addr);
      prev_rd = exp_rd;
    end

    @(negedge clk);
    mem_mode          = mode;
    bus.cpu_req_valid = 1'b1;
    bus.cpu_we        = we;
    bus.cpu_size      = size;
    bus.cpu_unsigned  = uns;
    bus.cpu_addr      = addr;
    bus.cpu_wdata     = wdata;
    check({tag, ".ready"}, 32'(bus.cpu_req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.cpu_req_valid = 1'b0;
    lat = 0; nreq = 0; got = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      if (bus.mem_req_valid && nreq < 8) begin
        obs_addr[nreq] = bus.mem_addr;
        obs_wd[nreq]   = bus.mem_wdata;
        obs_we[nreq]   = bus.mem_we;
        obs_oe[nreq]   = bus.mem_data_oe;
        nreq++;
      end
      if (bus.cpu_resp_valid) begin
        got = 1'b1;
        lat = c;
        check({tag, ".err"}, 32'(bus.cpu_err), 32'(exp_err));
        check({tag, ".rdata"}, bus.cpu_rdata, exp_rd);
      end
    end
    check({tag, ".resp_seen"}, 32'(got), 32'd1);
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".nreq"}, 32'(nreq), 32'(exp_nreq));
    for (int i = 0; i < nreq && i < exp_nreq; i++) begin
      check({tag, ".req_addr"}, obs_addr[i], exp_addr[i]);
      check({tag, ".req_we"}, 32'(obs_we[i]), 32'(we));
      check({tag, ".req_oe"}, 32'(obs_oe[i]), 32'(we));
      if (we) check({tag, ".req_wdata"}, obs_wd[i], {24'h0, exp_wd[i]});
    end
    @(posedge clk);
    #1;
    check({tag, ".resp_pulse"}, 32'(bus.cpu_resp_valid), 32'd0);
    check({tag, ".idle_ready"}, 32'(bus.cpu_req_ready), 32'd1);
    mem_mode = 0;
  endtask

  initial begin
    int nbusy;
    bus.cpu_req_valid = 1'b0;
    bus.cpu_we        = 1'b0;
    bus.cpu_size      = 2'b00;
    bus.cpu_unsigned  = 1'b0;
    bus.cpu_addr      = '0;
    bus.cpu_wdata     = '0;
    prev_rd           = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
    ref_mem[8'h10] = 8'h78; ref_mem[8'h11] = 8'h56;
    ref_mem[8'h12] = 8'h34; ref_mem[8'h13] = 8'h12;
    ref_mem[8'h20] = 8'h80; ref_mem[8'h21] = 8'h7F;

    repeat (3) @(posedge clk);
    #1;
    check("rst.ready", 32'(bus.cpu_req_ready), 32'd1);
    check("rst.resp_valid", 32'(bus.cpu_resp_valid), 32'd0);
    check("rst.err", 32'(bus.cpu_err), 32'd0);
    check("rst.rdata", bus.cpu_rdata, 32'd0);
    check("rst.mem_req", 32'(bus.mem_req_valid), 32'd0);
    check("rst.mem_we", 32'(bus.mem_we), 32'd0);
    check("rst.mem_oe", 32'(bus.mem_data_oe), 32'd0);
    check("rst.mem_addr", bus.mem_addr, 32'd0);
    check("rst.mem_wdata", bus.mem_wdata, 32'd0);
    @(negedge clk);
    reset   = 1'b0;
    preload = 1'b0;

    // Directed loads and stores
    run_req("lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
    check("lw10.value", prev_rd, 32'h1234_5678);
    run_req("lb20", 1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 0);
    check("lb20.value", prev_rd, 32'hFFFF_FF80);
    run_req("lbu20", 1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 0);
    check("lbu20.value", prev_rd, 32'h0000_0080);
    run_req("lh20", 1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 0);
    check("lh20.value", prev_rd, 32'h0000_7F80);
    run_req("sw40", 1'b1, 2'b10, 1'b0, 32'h40, 32'hAABB_CCDD, 0);
    run_req("lw40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 0);
    check("lw40.value", prev_rd, 32'hAABB_CCDD);
    run_req("sb", 1'b1, 2'b00, 1'b0, 32'h50, 32'h0000_00E7, 0);
    run_req("sh", 1'b1, 2'b01, 1'b0, 32'h52, 32'h0000_9A3C, 0);
    run_req("lwsh", 1'b0, 2'b10, 1'b0, 32'h50, 32'h0, 0);

    // Misaligned and illegal size
    run_req("lh21", 1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 0);
    run_req("sw42", 1'b1, 2'b10, 1'b0, 32'h42, 32'h1111_2222, 0);
    run_req("sz11", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 0);

    // Timeouts: memory never completes
    run_req("lw_to", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1);
    run_req("sw_to", 1'b1, 2'b10, 1'b0, 32'h60, 32'h5566_7788, 1);
    run_req("lw60", 1'b0, 2'b10, 1'b0, 32'h60, 32'h0, 0);

    // Reset during the second WR_WAIT of a word store
    @(negedge clk);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_we        = 1'b1;
    bus.cpu_size      = 2'b10;
    bus.cpu_addr      = 32'h80;
    bus.cpu_wdata     = 32'h1122_3344;
    @(posedge clk);
    #1;
    bus.cpu_req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rstmid.mem_req", 32'(bus.mem_req_valid), 32'd0);
    check("rstmid.ready", 32'(bus.cpu_req_ready), 32'd1);
    check("rstmid.resp_valid", 32'(bus.cpu_resp_valid), 32'd0);
    check("rstmid.rdata", bus.cpu_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ref_mem[8'h80] = 8'h44;
    ref_mem[8'h81] = 8'h33;
    prev_rd        = '0;
    nbusy = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (bus.mem_req_valid || bus.cpu_resp_valid) nbusy++;
    end
    check("rstmid.quiet", 32'(nbusy), 32'd0);
    run_req("lb81", 1'b0, 2'b00, 1'b0, 32'h81, 32'h0, 0);
    run_req("lb82", 1'b0, 2'b00, 1'b1, 32'h82, 32'h0, 0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      logic        we, uns;
      logic [1:0]  size;
      logic [31:0] addr;
      int          r;
      we   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      r    = $urandom_range(0, 9);
      size = (r == 9) ? 2'b11 : 2'(r % 3);
      addr = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0 && size != 2'b11) addr = addr & ~(32'(1 << size) - 32'd1);
      run_req("rand", we, size, uns, addr, $urandom, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
